// File: rtl/mc_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/add/shift ops plus an iterative shift-add MUL.
// Define MC_ALU_MUL_EN to build the multiplier; without it code 101 completes in one cycle with zero.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);

  localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [2:0] OP_MUL = 3'b101;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_result;
  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] result_next;

  assign shamt  = data2_i[SHW-1:0];
  assign accept = start_i && !busy_o;

  always_comb begin
    alu_result = '0;
    case (ALUCtrl_i)
      3'b000:  alu_result = data1_i & data2_i;
      3'b001:  alu_result = data1_i ^ data2_i;
      3'b010:  alu_result = data1_i << shamt;
      3'b011:  alu_result = data1_i + data2_i;
      3'b100:  alu_result = data1_i - data2_i;
      3'b110:  alu_result = data1_i + data2_i;
      3'b111:  alu_result = $signed(data1_i) >>> shamt;
      default: alu_result = '0;
    endcase
  end

`ifdef MC_ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sum;
  logic             last_step;

  assign acc_sum   = acc + (mplier[0] ? mcand : '0);
  assign last_step = (state == MUL) && (count == CW'(1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && ALUCtrl_i == OP_MUL) state_next = MUL;
      MUL:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == MUL);
  end

  // Shift-add engine: one multiplier bit consumed per MUL cycle.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (accept && ALUCtrl_i == OP_MUL) begin
      count  <= CW'(WIDTH);
      mcand  <= data1_i;
      mplier <= data2_i;
      acc    <= '0;
    end else if (state == MUL) begin
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  assign complete    = (accept && ALUCtrl_i != OP_MUL) || last_step;
  assign result_next = last_step ? acc_sum : alu_result;
`else
  always_comb begin
    busy_o = 1'b0;
  end

  assign complete    = accept;
  assign result_next = alu_result;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      done_o <= 1'b0;
      data_o <= '0;
      zero_o <= 1'b1;
    end else begin
      done_o <= complete;
      if (complete) begin
        data_o <= result_next;
        zero_o <= (result_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_mc_alu.sv
// Directed self-checking bench for mc_alu; covers the MUL path when MC_ALU_MUL_EN is defined.
module tb_mc_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  ctrl;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;

  int checkCount = 0;
  int errorCount = 0;

  mc_alu #(.WIDTH(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .ALUCtrl_i(ctrl),
    .data1_i(data1),
    .data2_i(data2),
    .busy_o(busy),
    .done_o(done),
    .data_o(result),
    .zero_o(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, i.e. the cycle after accept.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    ctrl  = op;
    data1 = a;
    data2 = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [31:0] expected, input logic expZero);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_data"}, result, expected);
    checkOutput({tag, "_zero"}, {31'd0, zero}, {31'd0, expZero});
  endtask

  initial begin
    int busyCycles;
    logic overlap;
    rst   = 1'b0;
    start = 1'b0;
    ctrl  = 3'b000;
    data1 = '0;
    data2 = '0;

    @(negedge clk);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_data", result, 32'd0);
    checkOutput("rst_zero", {31'd0, zero}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(3'b011, 32'd5, 32'd7);
    checkResult("add", 32'd12, 1'b0);
    @(negedge clk);
    checkOutput("idle_done", {31'd0, done}, 32'd0);
    checkOutput("idle_hold", result, 32'd12);

    // Back-to-back issues: done must stay high every cycle.
    applyStimulus(3'b100, 32'd5, 32'd5);
    checkResult("sub_zero", 32'd0, 1'b1);
    applyStimulus(3'b100, 32'd0, 32'd1);
    checkResult("sub_wrap", 32'hFFFF_FFFF, 1'b0);
    applyStimulus(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkResult("and", 32'hF000_F000, 1'b0);
    applyStimulus(3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00);
    checkResult("xor", 32'h0FF0_0FF0, 1'b0);
    applyStimulus(3'b110, 32'h10, 32'hFFFF_FFF0);
    checkResult("addi", 32'd0, 1'b1);
    applyStimulus(3'b010, 32'd1, 32'd31);
    checkResult("sll31", 32'h8000_0000, 1'b0);
    applyStimulus(3'b010, 32'd1, 32'd33);
    checkResult("sll33", 32'd2, 1'b0);
    applyStimulus(3'b111, 32'h8000_0000, 32'd4);
    checkResult("sra", 32'hF800_0000, 1'b0);

`ifdef MC_ALU_MUL_EN
    start = 1'b1;
    ctrl  = 3'b101;
    data1 = 32'hFFFF_FFFF;
    data2 = 32'd3;
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    overlap    = 1'b0;
    // A start at busy cycle 5 must be ignored entirely.
    for (int i = 0; i < 100 && busy; i++) begin
      busyCycles++;
      if (done) overlap = 1'b1;
      if (busyCycles == 5) begin
        start = 1'b1;
        ctrl  = 3'b011;
        data1 = 32'd1;
        data2 = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("mul_busy_cycles", busyCycles, 32'd32);
    checkOutput("mul_overlap", {31'd0, overlap}, 32'd0);
    checkOutput("mul_busy_end", {31'd0, busy}, 32'd0);
    checkResult("mul", 32'hFFFF_FFFD, 1'b0);
    applyStimulus(3'b011, 32'd9, 32'd1);
    checkResult("add_in_done", 32'd10, 1'b0);
    @(negedge clk);
    checkOutput("after_add_done", {31'd0, done}, 32'd0);

    start = 1'b1;
    ctrl  = 3'b101;
    data1 = 32'd6;
    data2 = 32'd7;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    checkOutput("abort_pre_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_data", result, 32'd0);
    checkOutput("abort_zero", {31'd0, zero}, 32'd1);
    overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done) overlap = 1'b1;
    end
    checkOutput("abort_no_done", {31'd0, overlap}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(3'b011, 32'd2, 32'd2);
    checkResult("add_after_abort", 32'd4, 1'b0);
`else
    applyStimulus(3'b101, 32'd6, 32'd7);
    checkResult("mul_disabled", 32'd0, 1'b1);
    checkOutput("mul_disabled_busy", {31'd0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mc_alu.md
# mc_alu

- Multi-cycle execute-stage ALU that consumes the 3-bit `ALUCtrl` code produced by the ALU control decoder.
- Single-cycle operations (logic, add/sub, shifts) return a registered result one cycle after issue.
- MUL uses an iterative shift-add engine that processes one multiplier bit per cycle.
- Sits between the ID/EX pipeline register and EX/MEM; the pipeline stalls on `busy_o`.

## Interface
- `WIDTH`, default 32: operand/result width; shift amount is `data2_i[$clog2(WIDTH)-1:0]`.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  issue request; accepted only when `busy_o`=0.
- `ALUCtrl_i`  in  3  operation code, sampled at accept.
- `data1_i`  in  WIDTH  operand A (rs1), sampled at accept.
- `data2_i`  in  WIDTH  operand B (rs2 or sign-extended immediate), sampled at accept.
- `busy_o`  out  1  MUL in progress.
- `done_o`  out  1  one-cycle pulse; `data_o` updated in the same cycle.
- `data_o`  out  WIDTH  result, held until the next completion.
- `zero_o`  out  1  registered `(data_o == 0)`.

## Operation
- Codes:
  - 000 AND
  - 001 XOR
  - 010 SLL by shamt
  - 011 ADD
  - 100 SUB (A−B)
  - 101 MUL (low WIDTH bits of A×B, signedness irrelevant for low half)
  - 110 ADD (immediate form)
  - 111 SRA by shamt (arithmetic)
- All arithmetic wraps modulo 2^WIDTH; no overflow flag.
- States: IDLE, MUL.
- IDLE + `start_i`=1, code ≠ 101:
  - compute combinationally, register into `data_o`/`zero_o` at the accepting edge;
  - `done_o`=1 for the following cycle; stay IDLE.
- IDLE + `start_i`=1, code = 101:
  - latch multiplicand A, multiplier B, clear accumulator, load bit counter with WIDTH; go to MUL.
- MUL, each edge:
  - if multiplier LSB = 1, accumulator += multiplicand;
  - multiplicand <<= 1, multiplier >>= 1, counter −1.
  - At the edge where the counter reaches 0: write accumulator to `data_o`, set `done_o`=1, return to IDLE.
- `start_i` while `busy_o`=1 is ignored: no queuing, operands not re-sampled.
- `start_i` during the `done_o` cycle is accepted (`busy_o` already 0).
- `done_o` is cleared every cycle unless a completion occurs.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `data_o`=0, `zero_o`=1, state IDLE, counter 0.
- Non-MUL latency: 1 cycle.
  - Accept at edge E0; `done_o`/`data_o` valid in the cycle after E0.
  - Back-to-back issue every cycle yields `done_o` every cycle.
- MUL latency: WIDTH cycles.
  - `busy_o`=1 for the WIDTH cycles following E0.
  - `done_o`=1 in the cycle after edge E_WIDTH, with `busy_o`=0 in that cycle.
- `busy_o` and `done_o` are never high together.
- Reset asserted mid-MUL aborts immediately (asynchronous): all outputs return to reset values with no `done_o` pulse; the first start after deassertion behaves normally.
- Shift amount ≥ WIDTH is impossible by construction (masked to `$clog2(WIDTH)` bits).

## Configuration
- `MC_ALU_MUL_EN` defined:
  - iterative multiplier as above.
- `MC_ALU_MUL_EN` undefined:
  - no multiplier state, counter or accumulator is built; FSM reduces to IDLE;
  - code 101 completes as a single-cycle op with `data_o`=0, `zero_o`=1;
  - `busy_o` is tied 0.

## Test plan
- ADD 5 + 7 (code 011) → `done_o` one cycle after accept, `data_o`=12, `zero_o`=0; SUB 5 − 5 (100) → `data_o`=0, `zero_o`=1; SUB 0 − 1 → 0xFFFFFFFF.
- AND 0xF0F0F0F0 & 0xFF00FF00 → 0xF000F000; XOR same operands → 0x0FF00FF0; ADD-imm (110) 0x10 + 0xFFFFFFF0 → 0.
- SLL 1 by `data2`=31 → 0x80000000; SLL 1 by `data2`=33 → 2 (masked); SRA 0x80000000 by 4 → 0xF8000000.
- MUL 0xFFFFFFFF × 3 → `busy_o` high exactly 32 cycles, then `done_o` with `data_o`=0xFFFFFFFD; a `start_i` ADD at busy cycle 5 is ignored; ADD issued in the `done_o` cycle completes next cycle.
- Reset pulled low at MUL busy cycle 10 → `busy_o`=0, `data_o`=0, `zero_o`=1 immediately, no `done_o`; after release, ADD 2 + 2 → 4.
- Build without `MC_ALU_MUL_EN`: MUL 6 × 7 → `done_o` after 1 cycle, `data_o`=0, `busy_o` never asserts.
